// File: rtl/ibex_multdiv_arbiter_if.sv
// Bus between the multdiv arbiter and the shared iterative multiply/divide unit.
// The master modport is the arbiter side; the slave modport is the unit side.
interface ibex_multdiv_arbiter_if;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_ready_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;

    modport master (
        output md_mult_en_o, md_div_en_o, md_operator_o, md_signed_o,
               md_op_a_o, md_op_b_o, md_ready_o,
        input  md_valid_i, md_result_i
    );

    modport slave (
        input  md_mult_en_o, md_div_en_o, md_operator_o, md_signed_o,
               md_op_a_o, md_op_b_o, md_ready_o,
        output md_valid_i, md_result_i
    );
endinterface

// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one iterative multdiv unit between NumReq requesters.
// Define IBEX_MD_ARB_RESULT_CACHE_EN to reuse the last completed result on an exact repeat.
module ibex_multdiv_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0][1:0]  req_operator_i,
    input  logic [NumReq-1:0][1:0]  req_signed_i,
    input  logic [NumReq-1:0][31:0] req_op_a_i,
    input  logic [NumReq-1:0][31:0] req_op_b_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    ibex_multdiv_arbiter_if.master  md
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    // Operator encoding follows ibex_pkg::md_op_e.
    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [1:0]      operator_q, operator_d;
    logic [1:0]      signed_q, signed_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [31:0]     result_q, result_d;

    logic            grant_found;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] cand_idx;
    int              cand;
    logic            accept;
    logic            cache_hit;

    // Scan from the slot after the last served owner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 0; off < int'(NumReq); off++) begin
            cand = int'(rr_q) + off;
            if (cand >= int'(NumReq)) begin
                cand = cand - int'(NumReq);
            end
            cand_idx = IdxW'(cand);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [1:0]  cache_operator_q, cache_operator_d;
    logic [1:0]  cache_signed_q, cache_signed_d;
    logic [31:0] cache_op_a_q, cache_op_a_d;
    logic [31:0] cache_op_b_q, cache_op_b_d;
    logic [31:0] cache_result_q, cache_result_d;

    assign cache_hit = cache_valid_q
                    && (req_operator_i[grant_idx] == cache_operator_q)
                    && (req_signed_i[grant_idx]   == cache_signed_q)
                    && (req_op_a_i[grant_idx]     == cache_op_a_q)
                    && (req_op_b_i[grant_idx]     == cache_op_b_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        operator_d = operator_q;
        signed_d   = signed_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        accept     = 1'b0;
`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
        cache_valid_d    = cache_valid_q;
        cache_operator_d = cache_operator_q;
        cache_signed_d   = cache_signed_q;
        cache_op_a_d     = cache_op_a_q;
        cache_op_b_d     = cache_op_b_q;
        cache_result_d   = cache_result_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    owner_d    = grant_idx;
                    operator_d = req_operator_i[grant_idx];
                    signed_d   = req_signed_i[grant_idx];
                    op_a_d     = req_op_a_i[grant_idx];
                    op_b_d     = req_op_b_i[grant_idx];
                    if (cache_hit) begin
`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
                        result_d = cache_result_q;
`endif
                        state_d  = RESP;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (md.md_valid_i) begin
                    result_d = md.md_result_i;
                    state_d  = RESP;
`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
                    cache_valid_d    = 1'b1;
                    cache_operator_d = operator_q;
                    cache_signed_d   = signed_q;
                    cache_op_a_d     = op_a_q;
                    cache_op_b_d     = op_b_q;
                    cache_result_d   = md.md_result_i;
`endif
                end
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                    if (owner_q == IdxW'(NumReq - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = owner_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            operator_q <= '0;
            signed_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            operator_q <= operator_d;
            signed_q   <= signed_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
        end
    end

`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
    // Only the valid bit needs clearing; stale payload is never compared without it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_valid_q <= 1'b0;
        end else begin
            cache_valid_q <= cache_valid_d;
        end
        cache_operator_q <= cache_operator_d;
        cache_signed_q   <= cache_signed_d;
        cache_op_a_q     <= cache_op_a_d;
        cache_op_b_q     <= cache_op_b_d;
        cache_result_q   <= cache_result_d;
    end
`endif

    for (genvar gi = 0; gi < int'(NumReq); gi++) begin : g_port
        assign req_ready_o[gi] = accept && (grant_idx == IdxW'(gi));
        assign rsp_valid_o[gi] = (state_q == RESP) && (owner_q == IdxW'(gi));
    end

    assign rsp_data_o       = result_q;
    assign md.md_mult_en_o  = (state_q == BUSY)
                           && ((operator_q == MD_OP_MULL) || (operator_q == MD_OP_MULH));
    assign md.md_div_en_o   = (state_q == BUSY)
                           && !((operator_q == MD_OP_MULL) || (operator_q == MD_OP_MULH));
    assign md.md_operator_o = operator_q;
    assign md.md_signed_o   = signed_q;
    assign md.md_op_a_o     = op_a_q;
    assign md.md_op_b_o     = op_b_q;
    assign md.md_ready_o    = (state_q == BUSY);

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_en_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(md.md_mult_en_o && md.md_div_en_o));
    a_busy_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == BUSY && state_d == BUSY) |=>
            $stable({operator_q, signed_q, op_a_q, op_b_q}));
endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with a behavioural multdiv unit and a response scoreboard.
module tb_ibex_multdiv_arbiter;
    localparam int NumReq = 2;
    localparam int Lat    = 4;
    localparam logic [1:0] MULL = 2'b00, MULH = 2'b01, DIV = 2'b10, REM = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NumReq-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NumReq-1:0][1:0]  req_operator, req_signed;
    logic [NumReq-1:0][31:0] req_op_a, req_op_b;
    logic [31:0]             rsp_data;

    ibex_multdiv_arbiter_if md_if ();

    ibex_multdiv_arbiter #(.NumReq(NumReq)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_operator_i (req_operator),
        .req_signed_i   (req_signed),
        .req_op_a_i     (req_op_a),
        .req_op_b_i     (req_op_b),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .md             (md_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Behavioural iterative unit: Lat enabled cycles, then a one-cycle valid.
    function automatic logic [31:0] md_model(logic [1:0] op, logic [1:0] sg,
                                             logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        sdiv;
        if (op == MULL) return a * b;
        if (op == MULH) begin
            ea = sg[0] ? {{32{a[31]}}, a} : {32'h0, a};
            eb = sg[1] ? {{32{b[31]}}, b} : {32'h0, b};
            p  = ea * eb;
            return p[63:32];
        end
        sdiv = sg[0] & sg[1];
        if (b == 32'h0) return (op == DIV) ? 32'hFFFFFFFF : a;
        if (sdiv && a == 32'h80000000 && b == 32'hFFFFFFFF) return (op == DIV) ? a : 32'h0;
        if (sdiv) return (op == DIV) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
        return (op == DIV) ? a / b : a % b;
    endfunction

    int          unit_cnt   = 0;
    int          en_cycles  = 0;
    int          overlap    = 0;
    int          stab_err   = 0;
    logic        unit_valid = 1'b0;
    logic [31:0] unit_res   = '0;
    logic [69:0] unit_snap  = '0;
    assign md_if.md_valid_i  = unit_valid;
    assign md_if.md_result_i = unit_res;

    always @(posedge clk) begin
        if (rst) begin
            unit_cnt   <= 0;
            unit_valid <= 1'b0;
        end else if (unit_valid) begin
            unit_valid <= 1'b0;
            unit_cnt   <= 0;
        end else if (md_if.md_mult_en_o || md_if.md_div_en_o) begin
            en_cycles <= en_cycles + 1;
            if (md_if.md_mult_en_o && md_if.md_div_en_o) overlap <= overlap + 1;
            if (md_if.md_mult_en_o != !md_if.md_operator_o[1] || !md_if.md_ready_o)
                stab_err <= stab_err + 1;
            if (unit_cnt == 0)
                unit_snap <= {md_if.md_operator_o, md_if.md_signed_o, md_if.md_op_a_o, md_if.md_op_b_o};
            else if (unit_snap != {md_if.md_operator_o, md_if.md_signed_o, md_if.md_op_a_o, md_if.md_op_b_o})
                stab_err <= stab_err + 1;
            unit_cnt <= unit_cnt + 1;
            if (unit_cnt == Lat - 1) begin
                unit_valid <= 1'b1;
                unit_res   <= md_model(md_if.md_operator_o, md_if.md_signed_o,
                                       md_if.md_op_a_o, md_if.md_op_b_o);
            end
        end
    end

    typedef struct {
        int          port;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_exp(int p, logic [31:0] d, string n);
        exp_t e;
        e.port = p;
        e.data = d;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed response handshake is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < NumReq; p++) begin
                    if (rsp_valid[p] && rsp_ready[p]) begin
                        check("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
                        check("no_grant_in_rsp", 32'(req_ready), 32'd0);
                        if (exp_q.size() == 0) begin
                            check("unexpected_rsp_port", 32'(p), 32'hFFFFFFFF);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check({mon_e.name, "_port"}, 32'(p), 32'(mon_e.port));
                            check({mon_e.name, "_data"}, rsp_data, mon_e.data);
                            $display("[TB] rsp %s port %0d data 0x%08h", mon_e.name, p, rsp_data);
                        end
                    end
                end
            end
        end
    end

    task automatic present(int p, logic [1:0] op, logic [1:0] sg, logic [31:0] a, logic [31:0] b);
        req_operator[p] = op;
        req_signed[p]   = sg;
        req_op_a[p]     = a;
        req_op_b[p]     = b;
        req_valid[p]    = 1'b1;
    endtask

    task automatic wait_accept(int p);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
            n++;
        end
        check("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic single(int p, logic [1:0] op, logic [1:0] sg, logic [31:0] a,
                          logic [31:0] b, logic [31:0] exp, string name);
        push_exp(p, exp, name);
        present(p, op, sg, a, b);
        wait_accept(p);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en_snap;
        req_valid    = '0;
        req_operator = '0;
        req_signed   = '0;
        req_op_a     = '0;
        req_op_b     = '0;
        rsp_ready    = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_md_ctrl", {29'd0, md_if.md_mult_en_o, md_if.md_div_en_o, md_if.md_ready_o}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_md_ops", md_if.md_op_a_o | md_if.md_op_b_o, 32'd0);
        @(posedge clk);
        #1;

        single(0, MULL, 2'b00, 32'd7, 32'd6, 32'h0000002A, "mull_7x6");
        single(0, DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_s");
        single(0, REM, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_s");
        single(1, DIV, 2'b00, 32'h00001234, 32'd0, 32'hFFFFFFFF, "divu_by0");
        single(1, REM, 2'b00, 32'd5, 32'd0, 32'h00000005, "remu_by0");

        // Reset while the unit is busy: nothing may come back afterwards.
        present(1, MULL, 2'b00, 32'd3, 32'd3);
        wait_accept(1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_md_en", {30'd0, md_if.md_mult_en_o, md_if.md_div_en_o}, 32'd0);
        repeat (Lat + 4) @(posedge clk);
        #1;
        check("rst_mid_quiet", {30'd0, rsp_valid}, 32'd0);

        // Both request after reset; R0 re-requests at once and must wait behind R1.
        push_exp(0, 32'h00000100, "rr_r0a");
        push_exp(1, 32'hFFFFFFFE, "rr_r1");
        push_exp(0, 32'h0000000E, "rr_r0b");
        present(0, MULL, 2'b00, 32'h10, 32'h10);
        present(1, MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_accept(0);
        present(0, DIV, 2'b00, 32'd100, 32'd7);
        wait_accept(1);
        wait_accept(0);
        drain();

        // Last winner was R0, so R1 goes first on each simultaneous pair.
        push_exp(1, 32'hFFFFFFFE, "alt_r1");
        push_exp(0, 32'h00020001, "alt_r0");
        present(0, MULL, 2'b11, 32'h00010001, 32'h00010001);
        present(1, REM, 2'b11, 32'hFFFFFF9C, 32'd7);
        wait_accept(1);
        wait_accept(0);
        drain();
        push_exp(1, 32'h80000000, "ovf_div_r1");
        push_exp(0, 32'h00000000, "ovf_rem_r0");
        present(0, REM, 2'b11, 32'h80000000, 32'hFFFFFFFF);
        present(1, DIV, 2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_accept(1);
        wait_accept(0);
        drain();

        // Response held off for 10 cycles while R1 waits; R1 ready on its own port is ignored.
        rsp_ready[0] = 1'b0;
        push_exp(0, 32'h0000000F, "hold_r0");
        push_exp(1, 32'h0000000A, "hold_r1");
        present(0, MULL, 2'b00, 32'd3, 32'd5);
        wait_accept(0);
        n = 0;
        while (!rsp_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_timeout", {31'd0, rsp_valid[0]}, 32'd1);
        @(posedge clk);
        #1;
        present(1, DIV, 2'b00, 32'h64, 32'h0A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", rsp_data, 32'h0000000F);
            check("hold_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        wait_accept(1);
        drain();

        // Repeated MULH: served from the stored result when the cache is built in.
        single(0, MULH, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_first");
        push_exp(0, 32'h40000000, "mulh_repeat");
        en_snap = en_cycles;
        present(0, MULH, 2'b11, 32'h80000000, 32'h80000000);
        wait_accept(0);
`ifdef IBEX_MD_ARB_RESULT_CACHE_EN
        @(negedge clk);
        check("cache_latency", {31'd0, rsp_valid[0]}, 32'd1);
        drain();
        check("cache_unit_idle", 32'(en_cycles - en_snap), 32'd0);
`else
        drain();
        check("nocache_unit_used", 32'(en_cycles != en_snap), 32'd1);
`endif

        repeat (4) @(posedge clk);
        check("md_en_overlap", 32'(overlap), 32'd0);
        check("md_operand_stability", 32'(stab_err), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
